// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: valid/ready handshake with a two-entry skid buffer,
// writeback data select, ROB completion tag, flush and ROB-age selective kill.
module mem_wb_stage #(
   parameter int XLEN  = 32,
   parameter int REG_W = 5,
   parameter int ROB_W = 4,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_alu_out,
   input  logic [XLEN-1:0]  in_mem_out,
   input  logic [REG_W-1:0] in_rd,
   input  logic             in_mem_to_reg,
   input  logic             in_write_enable,
   input  logic             in_complete,
   input  logic [ROB_W-1:0] in_complete_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_wb_data,
   output logic [REG_W-1:0] out_rd,
   output logic             out_write_enable,
   output logic             out_complete,
   output logic [ROB_W-1:0] out_complete_idx,
   input  logic             flush,
   input  logic             kill_valid,
   input  logic [ROB_W-1:0] kill_idx,
   input  logic [ROB_W-1:0] rob_head,
   output logic             fwd_valid,
   output logic [REG_W-1:0] fwd_rd,
   output logic [XLEN-1:0]  fwd_data,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic [XLEN-1:0]  wb_data;
      logic [REG_W-1:0] rd;
      logic             write_enable;
      logic             complete;
      logic [ROB_W-1:0] complete_idx;
   } entry_t;

   entry_t           main_q, main_d, skid_q, skid_d;
   entry_t           in_entry, slot_a, slot_b;
   logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
   logic             slot_a_valid, slot_b_valid, keep_a, keep_b;
   logic             fire_in, stall_inc;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Offsets from the ROB head make the age compare immune to index wrap.
   function automatic logic is_younger(input logic [ROB_W-1:0] idx,
                                       input logic [ROB_W-1:0] head,
                                       input logic [ROB_W-1:0] kidx);
      logic [ROB_W-1:0] off_idx;
      logic [ROB_W-1:0] off_kill;
      off_idx  = idx - head;
      off_kill = kidx - head;
      return off_idx > off_kill;
   endfunction

   always_comb begin
      in_entry.wb_data      = in_mem_to_reg ? in_mem_out : in_alu_out;
      in_entry.rd           = in_rd;
      in_entry.write_enable = in_write_enable & (in_rd != '0);
      in_entry.complete     = in_complete;
      in_entry.complete_idx = in_complete_idx;
   end

   assign fire_in   = in_valid & in_ready;
   assign stall_inc = main_valid_q & ~out_ready;

   // Slot A/B are the retained entries in FIFO order; kill filters them,
   // then the survivors are compacted into main then skid.
   always_comb begin
      slot_a       = in_entry;
      slot_a_valid = fire_in;
      slot_b       = in_entry;
      slot_b_valid = 1'b0;
      if (main_valid_q && !out_ready) begin
         slot_a       = main_q;
         slot_a_valid = 1'b1;
         slot_b       = skid_valid_q ? skid_q : in_entry;
         slot_b_valid = skid_valid_q | fire_in;
      end else if (skid_valid_q) begin
         slot_a       = skid_q;
         slot_a_valid = 1'b1;
      end

      keep_a = slot_a_valid &
               ~(kill_valid & is_younger(slot_a.complete_idx, rob_head, kill_idx));
      keep_b = slot_b_valid &
               ~(kill_valid & is_younger(slot_b.complete_idx, rob_head, kill_idx));

      main_valid_d = keep_a | keep_b;
      main_d       = keep_a ? slot_a : (keep_b ? slot_b : main_q);
      skid_valid_d = keep_a & keep_b;
      skid_d       = (keep_a & keep_b) ? slot_b : skid_q;
      stall_cnt_d  = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall_inc};

      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         stall_cnt_d  = stall_cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_q       <= '0;
         skid_q       <= '0;
         stall_cnt_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_q       <= main_d;
         skid_q       <= skid_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign in_ready         = ~skid_valid_q;
   assign out_valid        = main_valid_q;
   assign out_wb_data      = main_q.wb_data;
   assign out_rd           = main_q.rd;
   assign out_write_enable = main_valid_q & main_q.write_enable;
   assign out_complete     = main_valid_q & main_q.complete;
   assign out_complete_idx = main_q.complete_idx;
   assign fwd_valid        = out_valid & out_write_enable;
   assign fwd_rd           = out_rd;
   assign fwd_data         = out_wb_data;
   assign stall_cnt        = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: stimulus pushes expected entries, a
// negedge monitor pops and compares every delivered head entry.
module tb_mem_wb_stage;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_alu_out;
   logic [31:0] in_mem_out;
   logic [4:0]  in_rd;
   logic        in_mem_to_reg;
   logic        in_write_enable;
   logic        in_complete;
   logic [3:0]  in_complete_idx;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_wb_data;
   logic [4:0]  out_rd;
   logic        out_write_enable;
   logic        out_complete;
   logic [3:0]  out_complete_idx;
   logic        flush;
   logic        kill_valid;
   logic [3:0]  kill_idx;
   logic [3:0]  rob_head;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
   logic [31:0] stall_cnt;

   typedef struct {
      logic [31:0] wb;
      logic [4:0]  rd;
      logic        we;
      logic        cmp;
      logic [3:0]  idx;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   wait_cycles = 0;

   mem_wb_stage #(.XLEN(32), .REG_W(5), .ROB_W(4), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_out(in_alu_out), .in_mem_out(in_mem_out), .in_rd(in_rd),
      .in_mem_to_reg(in_mem_to_reg), .in_write_enable(in_write_enable),
      .in_complete(in_complete), .in_complete_idx(in_complete_idx),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_wb_data(out_wb_data), .out_rd(out_rd),
      .out_write_enable(out_write_enable), .out_complete(out_complete),
      .out_complete_idx(out_complete_idx),
      .flush(flush), .kill_valid(kill_valid), .kill_idx(kill_idx),
      .rob_head(rob_head),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .stall_cnt(stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   // Holds in_valid until the entry is accepted, then records what must come out.
   task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] mem,
                                input logic m2r, input logic [4:0] rd,
                                input logic we, input logic cmp,
                                input logic [3:0] idx);
      logic acc;
      int   guard;
      exp_t e;
      in_valid        = 1'b1;
      in_alu_out      = alu;
      in_mem_out      = mem;
      in_mem_to_reg   = m2r;
      in_rd           = rd;
      in_write_enable = we;
      in_complete     = cmp;
      in_complete_idx = idx;
      guard = 0;
      do begin
         acc = in_ready;
         @(posedge clk);
         #1;
         if (!acc) begin
            wait_cycles++;
            guard++;
         end
      end while (!acc && guard < 50);
      in_valid = 1'b0;
      if (acc) begin
         e.wb  = m2r ? mem : alu;
         e.rd  = rd;
         e.we  = we && (rd != 5'd0);
         e.cmp = cmp;
         e.idx = idx;
         sb.push_back(e);
      end else begin
         checks++;
         failures++;
         $display("[TB] FAIL accept_timeout actual=in_ready_low expected=accepted");
      end
   endtask

   task automatic waitDrain(input string name);
      int g;
      g = 0;
      while (sb.size() != 0 && g < 40) begin
         @(posedge clk);
         #1;
         g++;
      end
      checkOutput(name, 64'(sb.size()), 64'd0);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      checkOutput({tag, "_out_wb_data"}, 64'(out_wb_data), 64'd0);
      checkOutput({tag, "_out_rd"}, 64'(out_rd), 64'd0);
      checkOutput({tag, "_out_we"}, 64'(out_write_enable), 64'd0);
      checkOutput({tag, "_out_complete"}, 64'(out_complete), 64'd0);
      checkOutput({tag, "_out_idx"}, 64'(out_complete_idx), 64'd0);
      checkOutput({tag, "_fwd_valid"}, 64'(fwd_valid), 64'd0);
      checkOutput({tag, "_fwd_rd"}, 64'(fwd_rd), 64'd0);
      checkOutput({tag, "_fwd_data"}, 64'(fwd_data), 64'd0);
      checkOutput({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
   endtask

   // Monitor: a head entry presented with out_ready high is consumed at the next edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL sb_unexpected actual=rd%0d expected=no_output", out_rd);
            end else begin
               e = sb.pop_front();
               checkOutput("sb_wb_data", 64'(out_wb_data), 64'(e.wb));
               checkOutput("sb_rd", 64'(out_rd), 64'(e.rd));
               checkOutput("sb_we", 64'(out_write_enable), 64'(e.we));
               checkOutput("sb_complete", 64'(out_complete), 64'(e.cmp));
               checkOutput("sb_idx", 64'(out_complete_idx), 64'(e.idx));
               checkOutput("sb_fwd_data", 64'(fwd_data), 64'(e.wb));
            end
         end
      end
   end

   initial begin
      int   w0;
      logic [31:0] s0;
      reset = 1'b1;
      in_valid = 1'b0; in_alu_out = '0; in_mem_out = '0; in_rd = '0;
      in_mem_to_reg = 1'b0; in_write_enable = 1'b0; in_complete = 1'b0;
      in_complete_idx = '0; out_ready = 1'b0; flush = 1'b0;
      kill_valid = 1'b0; kill_idx = '0; rob_head = '0;
      repeat (3) @(posedge clk);
      #1;
      checkResetValues("reset");
      reset = 1'b0;

      // Single entry, load data selected
      out_ready = 1'b1;
      applyStimulus(32'h11, 32'h22, 1'b1, 5'd5, 1'b1, 1'b1, 4'd3);
      checkOutput("t1_out_valid", 64'(out_valid), 64'd1);
      checkOutput("t1_out_wb_data", 64'(out_wb_data), 64'h22);
      checkOutput("t1_fwd_valid", 64'(fwd_valid), 64'd1);
      checkOutput("t1_fwd_rd", 64'(fwd_rd), 64'd5);

      // Streaming at full rate
      w0 = wait_cycles;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(32'h100 + 32'(i), 32'h200 + 32'(i), i[0], 5'(i + 1),
                       1'b1, i[1], 4'(i));
      end
      checkOutput("stream_in_ready_low_cycles", 64'(wait_cycles - w0), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("stream_drained", 64'(sb.size()), 64'd0);
      checkOutput("stream_out_valid", 64'(out_valid), 64'd0);

      // Backpressure: A main, B skid, C held upstream
      out_ready = 1'b0;
      s0 = stall_cnt;
      applyStimulus(32'hA, 32'h0, 1'b0, 5'd10, 1'b1, 1'b1, 4'd4);
      applyStimulus(32'hB, 32'h0, 1'b0, 5'd11, 1'b1, 1'b1, 4'd5);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_head_rd", 64'(out_rd), 64'd10);
      fork
         applyStimulus(32'hC, 32'h0, 1'b0, 5'd12, 1'b1, 1'b1, 4'd6);
         begin
            repeat (2) @(posedge clk);
            #1;
            checkOutput("bp_stall_cnt", 64'(stall_cnt), 64'(s0 + 32'd3));
            out_ready = 1'b1;
         end
      join
      checkOutput("bp_c_in_main_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_c_in_main_rd", 64'(out_rd), 64'd12);
      waitDrain("bp_drain");
      checkOutput("bp_stall_cnt_final", 64'(stall_cnt), 64'(s0 + 32'd3));

      // Selective kill with ROB index wrap: head=14, main idx=15, skid idx=1
      out_ready = 1'b0;
      rob_head = 4'd14;
      applyStimulus(32'h77, 32'h0, 1'b0, 5'd7, 1'b1, 1'b1, 4'd15);
      applyStimulus(32'h88, 32'h0, 1'b0, 5'd8, 1'b1, 1'b1, 4'd1);
      kill_valid = 1'b1; kill_idx = 4'd0;
      @(posedge clk);
      #1;
      kill_valid = 1'b0;
      void'(sb.pop_back());
      checkOutput("kill0_in_ready", 64'(in_ready), 64'd1);
      checkOutput("kill0_out_valid", 64'(out_valid), 64'd1);
      checkOutput("kill0_main_idx", 64'(out_complete_idx), 64'd15);
      applyStimulus(32'h88, 32'h0, 1'b0, 5'd8, 1'b1, 1'b1, 4'd1);
      kill_valid = 1'b1; kill_idx = 4'd15;
      @(posedge clk);
      #1;
      kill_valid = 1'b0;
      void'(sb.pop_back());
      checkOutput("kill15_in_ready", 64'(in_ready), 64'd1);
      checkOutput("kill15_main_idx", 64'(out_complete_idx), 64'd15);
      applyStimulus(32'h88, 32'h0, 1'b0, 5'd8, 1'b1, 1'b1, 4'd1);
      kill_valid = 1'b1; kill_idx = 4'd1;
      @(posedge clk);
      #1;
      kill_valid = 1'b0;
      checkOutput("kill1_in_ready", 64'(in_ready), 64'd0);
      checkOutput("kill1_out_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      waitDrain("kill_drain");

      // rd=0 write is suppressed but the entry still flows
      out_ready = 1'b0;
      applyStimulus(32'h55, 32'h66, 1'b0, 5'd0, 1'b1, 1'b0, 4'd2);
      checkOutput("rd0_out_valid", 64'(out_valid), 64'd1);
      checkOutput("rd0_out_we", 64'(out_write_enable), 64'd0);
      checkOutput("rd0_fwd_valid", 64'(fwd_valid), 64'd0);
      checkOutput("rd0_wb_data", 64'(out_wb_data), 64'h55);
      out_ready = 1'b1;
      waitDrain("rd0_drain");

      // Flush with both entries full, incoming and kill all at once
      out_ready = 1'b0;
      applyStimulus(32'h1, 32'h0, 1'b0, 5'd1, 1'b1, 1'b1, 4'd3);
      applyStimulus(32'h2, 32'h0, 1'b0, 5'd2, 1'b1, 1'b1, 4'd4);
      s0 = stall_cnt;
      flush = 1'b1; kill_valid = 1'b1; kill_idx = 4'd3;
      in_valid = 1'b1; in_alu_out = 32'h3; in_rd = 5'd3; in_complete_idx = 4'd5;
      sb.delete();
      @(posedge clk);
      #1;
      flush = 1'b0; kill_valid = 1'b0; in_valid = 1'b0;
      checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
      checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
      checkOutput("flush_stall_cnt", 64'(stall_cnt), 64'(s0));
      @(posedge clk);
      #1;
      checkOutput("flush_incoming_dropped", 64'(out_valid), 64'd0);

      // Reset in the middle of a stall
      applyStimulus(32'h9, 32'h0, 1'b0, 5'd9, 1'b1, 1'b1, 4'd6);
      applyStimulus(32'hA, 32'h0, 1'b0, 5'd9, 1'b1, 1'b1, 4'd7);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      checkResetValues("midreset");
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
